// File: rtl/count_n_updown.sv
// count_n_updown: mod-MODULUS up/down counter with wrap/saturate end modes,
// clamped parallel load, combinational terminal count for cascading, and a
// registered one-cycle wrap pulse.
module count_n_updown #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  // Highest legal count; fits in WIDTH bits even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAX);
  assign at_zero = (count_q == '0);

  // Terminal count looks only at the enable, the direction and the current
  // state, so a following stage sees it in the same cycle.
  assign tc = enable & ((up & at_max) | (~up & at_zero));

  // Next-state selection: load beats counting. Increment and decrement only
  // happen away from the boundary, so the result never leaves 0..MAX and
  // never overflows WIDTH bits.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
    end else if (enable) begin
      if (up) begin
        if (!at_max) begin
          count_d = count_q + 1'b1;
        end else if (!sat) begin
          count_d   = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - 1'b1;
        end else if (!sat) begin
          count_d   = MAX;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  // State register; clr is sampled on the edge and overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_count_n_updown.sv
// Directed bench for count_n_updown: a MODULUS=10 instance, a two-digit
// decade chain, and a full-range MODULUS=16 instance.
module tb_count_n_updown;

  logic       clk = 1'b0;
  logic       clr, enable, up, sat, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrapped;

  // Chain signals.
  logic       c_clr, c_en, c_up;
  logic [3:0] lo_cnt, hi_cnt;
  logic       lo_tc, hi_tc, lo_wr, hi_wr;

  // Full-range instance signals.
  logic [3:0] f_cnt;
  logic       f_tc, f_wr;

  int n_chk = 0;
  int n_err = 0;
  int m;

  always #5 clk = ~clk;

  count_n_updown #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk(clk), .clr(clr), .enable(enable), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrapped(wrapped)
  );

  count_n_updown #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .clr(c_clr), .enable(c_en), .up(c_up), .sat(1'b0), .load(1'b0),
    .load_val(4'd0), .count(lo_cnt), .tc(lo_tc), .wrapped(lo_wr)
  );

  count_n_updown #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .clr(c_clr), .enable(lo_tc), .up(c_up), .sat(1'b0), .load(1'b0),
    .load_val(4'd0), .count(hi_cnt), .tc(hi_tc), .wrapped(hi_wr)
  );

  count_n_updown #(.WIDTH(4), .MODULUS(16)) u_full (
    .clk(clk), .clr(clr), .enable(enable), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(f_cnt), .tc(f_tc), .wrapped(f_wr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dn[5];
    dn = '{1, 0, 0, 0, 0};
    clr = 1; enable = 0; up = 1; sat = 0; load = 0; load_val = 0;
    c_clr = 1; c_en = 0; c_up = 1;
    repeat (2) cyc();
    chk("rst_cnt", count, 0);
    chk("rst_wrap", wrapped, 0);
    chk("rst_tc", tc, 0);

    // Wrapping up-count through the boundary.
    clr = 0; enable = 1; up = 1; sat = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("up_cnt", count, i % 10);
      chk("up_tc", tc, (i % 10) == 9);
      cyc();
      chk("up_wrap", wrapped, (i % 10) == 9);
    end
    chk("up_end", count, 2);

    // Saturating down-count from 2.
    up = 0; sat = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("dsat_cnt", count, dn[i]);
      chk("dsat_wrap", wrapped, 0);
      #1;
      chk("dsat_tc", tc, dn[i] == 0);
    end

    // Down wrap 0 -> 9, then saturate-hold at 9 going up.
    sat = 0;
    cyc();
    chk("dwrap_cnt", count, 9);
    chk("dwrap_wrap", wrapped, 1);
    up = 1; sat = 1;
    #1;
    chk("usat_tc", tc, 1);
    cyc();
    chk("usat_cnt", count, 9);
    chk("usat_wrap", wrapped, 0);

    // Loads: clamp, load while disabled, load beats a wrap.
    load = 1; load_val = 13; enable = 1; sat = 0;
    cyc();
    chk("ld_clamp", count, 9);
    load_val = 5; enable = 0;
    cyc();
    chk("ld_noen", count, 5);
    load_val = 9;
    cyc();
    load_val = 3; enable = 1; up = 1;
    cyc();
    chk("ld_prio", count, 3);
    chk("ld_wrap", wrapped, 0);

    // Enable gating: 5 frozen / 20 counting, twice, starting from 9.
    load_val = 9;
    cyc();
    load = 0;
    m = 9;
    for (int r = 0; r < 2; r++) begin
      enable = 0;
      for (int i = 0; i < 5; i++) begin
        #1;
        chk("gate_tc", tc, 0);
        cyc();
        chk("gate_hold", count, m);
      end
      enable = 1;
      for (int i = 0; i < 20; i++) begin
        m = (m + 1) % 10;
        cyc();
        chk("gate_cnt", count, m);
      end
    end

    // clr with load at count 6.
    load = 1; load_val = 6;
    cyc();
    chk("ld6", count, 6);
    clr = 1; load_val = 3;
    cyc();
    chk("clrld_cnt", count, 0);
    chk("clrld_wrap", wrapped, 0);
    // clr beats a pending wrap.
    clr = 0; load_val = 9;
    cyc();
    load = 0; clr = 1; enable = 1; up = 1; sat = 0;
    #1;
    chk("clrwr_tc", tc, 1);
    cyc();
    chk("clrwr_cnt", count, 0);
    chk("clrwr_wrap", wrapped, 0);
    // tc during clr going down; restart counts to 1.
    up = 0;
    #1;
    chk("clr_tc", tc, 1);
    clr = 0; up = 1;
    cyc();
    chk("restart", count, 1);

    // Full-range modulus: no clamp, wrap at 15 both ways.
    clr = 1;
    cyc();
    clr = 0; load = 1; load_val = 15;
    cyc();
    chk("full_ld", f_cnt, 15);
    load = 0; enable = 1; up = 1; sat = 0;
    #1;
    chk("full_tc", f_tc, 1);
    cyc();
    chk("full_up", f_cnt, 0);
    chk("full_upw", f_wr, 1);
    up = 0;
    cyc();
    chk("full_dn", f_cnt, 15);
    chk("full_dnw", f_wr, 1);

    // Two-digit chain.
    c_clr = 0; c_en = 1; c_up = 1;
    repeat (12) cyc();
    chk("ch12_hi", hi_cnt, 1);
    chk("ch12_lo", lo_cnt, 2);
    repeat (108) cyc();
    chk("ch120_hi", hi_cnt, 2);
    chk("ch120_lo", lo_cnt, 0);
    c_clr = 1;
    cyc();
    c_clr = 0; c_up = 0;
    cyc();
    chk("ch99_hi", hi_cnt, 9);
    chk("ch99_lo", lo_cnt, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
